// File: rtl/ysyx_22041211_ifu_prefetch.sv
// ysyx_22041211_ifu_prefetch: prefetching IFU with an in-order fetch FIFO and redirect flush.
// Define YSYX_22041211_IFU_MISALIGN_CHECK_EN to turn misaligned redirect targets into fault entries.
module ysyx_22041211_ifu_prefetch #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_target_i,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
    input  logic                  mem_resp_valid_i,
    input  logic [DATA_WIDTH-1:0] mem_resp_data_i,
    input  logic                  mem_resp_err_i,
    output logic                  inst_valid_o,
    input  logic                  inst_ready_i,
    output logic [DATA_WIDTH-1:0] inst_o,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic                  fault_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [ADDR_WIDTH-1:0] fetch_pc, target;
    logic [CW-1:0]         outstanding, kill_cnt, count;
    logic [CW:0]           used;
    logic [PW-1:0]         rd_ptr, wr_ptr, fl_rd, fl_wr;
    logic [ADDR_WIDTH-1:0] pc_mem [DEPTH];
    logic [DATA_WIDTH-1:0] inst_mem [DEPTH];
    logic                  fault_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] fl_pc [DEPTH];
    logic                  stopped, mis_pend, misaligned;
    logic                  req_fire, resp_ok, push, push_fault, pop;

`ifdef YSYX_22041211_IFU_MISALIGN_CHECK_EN
    assign misaligned = |redirect_target_i[1:0];
    assign target     = redirect_target_i;
`else
    assign misaligned = 1'b0;
    assign target     = redirect_target_i & ~ADDR_WIDTH'(3);
`endif

    // Killed requests still occupy the in-flight queue, so outstanding is capped too.
    assign used            = {1'b0, outstanding} - {1'b0, kill_cnt} + {1'b0, count};
    assign mem_req_valid_o = !redirect_i && !stopped && used < (CW+1)'(DEPTH) && outstanding < CW'(DEPTH);
    assign mem_req_addr_o  = fetch_pc;
    assign req_fire        = mem_req_valid_o && mem_req_ready_i;
    assign resp_ok         = mem_resp_valid_i && outstanding != '0;
    assign push            = resp_ok && kill_cnt == '0 && !redirect_i;
    assign push_fault      = mis_pend && !redirect_i && count < CW'(DEPTH);
    assign inst_valid_o    = count != '0;
    assign pop             = inst_valid_o && inst_ready_i && !redirect_i;
    assign inst_o          = inst_valid_o ? inst_mem[rd_ptr] : '0;
    assign pc_o            = inst_valid_o ? pc_mem[rd_ptr] : '0;
    assign fault_o         = inst_valid_o && fault_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            kill_cnt    <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fl_rd       <= '0;
            fl_wr       <= '0;
            stopped     <= 1'b0;
            mis_pend    <= 1'b0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(resp_ok);
            if (req_fire) begin
                fl_wr    <= fl_wr + PW'(1);
                fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
            end
            if (resp_ok) fl_rd <= fl_rd + PW'(1);
            if (redirect_i) begin
                fetch_pc <= target;
                kill_cnt <= outstanding - CW'(resp_ok);
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                stopped  <= misaligned;
                mis_pend <= misaligned;
            end else begin
                if (resp_ok && kill_cnt != '0) kill_cnt <= kill_cnt - CW'(1);
                if (push || push_fault) wr_ptr <= wr_ptr + PW'(1);
                if (pop) rd_ptr <= rd_ptr + PW'(1);
                if (push_fault) mis_pend <= 1'b0;
                count <= count + CW'(push || push_fault) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) fl_pc[fl_wr] <= fetch_pc;
        if (push || push_fault) begin
            pc_mem[wr_ptr]    <= push_fault ? fetch_pc : fl_pc[fl_rd];
            inst_mem[wr_ptr]  <= push_fault ? '0 : mem_resp_data_i;
            fault_mem[wr_ptr] <= push_fault || mem_resp_err_i;
        end
    end
endmodule
